// File: rtl/mips_trace_pkg.sv
// Shared MIPS decode constants and trace record definitions used by the
// retire-trace buffer and its instruction classifier.
package mips_trace_pkg;

  localparam int CLS_W   = 4;
  localparam int NUM_CLS = 10;

  localparam logic [CLS_W-1:0] CLS_OTHER = 4'd0;
  localparam logic [CLS_W-1:0] CLS_ADD   = 4'd1;
  localparam logic [CLS_W-1:0] CLS_SUB   = 4'd2;
  localparam logic [CLS_W-1:0] CLS_AND   = 4'd3;
  localparam logic [CLS_W-1:0] CLS_OR    = 4'd4;
  localparam logic [CLS_W-1:0] CLS_ORI   = 4'd5;
  localparam logic [CLS_W-1:0] CLS_LW    = 4'd6;
  localparam logic [CLS_W-1:0] CLS_SW    = 4'd7;
  localparam logic [CLS_W-1:0] CLS_BEQ   = 4'd8;
  localparam logic [CLS_W-1:0] CLS_J     = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE
  } trace_state_e;

  // Record layout at the default widths; rec_w() gives the width for any sizing.
  typedef struct packed {
    logic [15:0]      cycle;
    logic [31:0]      pc;
    logic [CLS_W-1:0] cls;
    logic [31:0]      wd;
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

  function automatic int rec_w(int pc_w, int data_w, int cyc_w);
    return cyc_w + pc_w + CLS_W + data_w;
  endfunction

endpackage

// File: rtl/mips_instr_classify.sv
// Combinational classifier: maps a MIPS instruction word onto a trace class code.
module mips_instr_classify
  import mips_trace_pkg::*;
(
  input  logic [31:0]      instr,
  output logic [CLS_W-1:0] cls
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    cls = CLS_OTHER;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  cls = CLS_ADD;
          FN_SUB:  cls = CLS_SUB;
          FN_AND:  cls = CLS_AND;
          FN_OR:   cls = CLS_OR;
          default: cls = CLS_OTHER;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      default: cls = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/mips_trace_buffer.sv
// Retire-trace capture: classifies retiring instructions, stores stamped
// records in a circular buffer with show-ahead valid/ready readout.
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int CYC_W  = 16,
  parameter int CNT_W  = 16,
  localparam int FW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              retire_valid,
  input  logic [PC_W-1:0]   retire_pc,
  input  logic [31:0]       retire_instr,
  input  logic [DATA_W-1:0] retire_wd,
  input  logic              cap_en,
  input  logic              wrap_mode,
  input  logic              trig_en,
  input  logic [PC_W-1:0]   trig_pc,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CYC_W-1:0]  rd_cycle,
  output logic [PC_W-1:0]   rd_pc,
  output logic [CLS_W-1:0]  rd_class,
  output logic [DATA_W-1:0] rd_wd,
  output logic [FW-1:0]     fill,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic [CLS_W-1:0]  cls_sel,
  output logic [CNT_W-1:0]  cls_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  trace_state_e      state_q, state_d;
  logic [CYC_W-1:0]  cyc_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              overflow_q;
  logic [CNT_W-1:0]  drop_q;
  logic [CNT_W-1:0]  cnt_q [NUM_CLS];

  logic [CYC_W-1:0]  cyc_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem  [DEPTH];
  logic [CLS_W-1:0]  cls_mem [DEPTH];
  logic [DATA_W-1:0] wd_mem  [DEPTH];

  logic [CLS_W-1:0]  ret_cls;
  logic              trig_hit, elig, full, pop, do_write, overwrite, lost;

  mips_instr_classify u_classify (
    .instr (retire_instr),
    .cls   (ret_cls)
  );

  // The trigger instruction is eligible in the same cycle the FSM leaves ARMED.
  assign trig_hit = (state_q == ST_ARMED) && cap_en && retire_valid &&
                    (retire_pc == trig_pc);
  assign elig     = retire_valid && ((state_q == ST_CAPTURE) || trig_hit);

  always_comb begin
    state_d = state_q;
    if (!cap_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = trig_en ? ST_ARMED : ST_CAPTURE;
        ST_ARMED: if (trig_hit) state_d = ST_CAPTURE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_q + CYC_W'(1);
    end
  end

  assign full      = (fill_q == FW'(DEPTH));
  assign rd_valid  = (fill_q != '0);
  assign pop       = rd_valid && rd_ready;
  assign do_write  = elig && (!full || pop || wrap_mode);
  // When full the write pointer equals the read pointer, so overwriting
  // replaces the oldest record and the head must move past it.
  assign overwrite = elig && full && !pop && wrap_mode;
  assign lost      = elig && full && !pop;

  always_comb begin
    fill_d   = fill_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_write)         wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop || overwrite) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_write && !overwrite && !pop) fill_d = fill_q + FW'(1);
    else if (pop && !do_write)          fill_d = fill_q - FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      if (lost) begin
        overflow_q <= 1'b1;
        if (drop_q != CNT_MAX) drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      cyc_mem[wr_ptr_q] <= cyc_q;
      pc_mem[wr_ptr_q]  <= retire_pc;
      cls_mem[wr_ptr_q] <= ret_cls;
      wd_mem[wr_ptr_q]  <= retire_wd;
    end
  end

  for (genvar g = 0; g < NUM_CLS; g++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst)
        cnt_q[g] <= '0;
      else if (elig && (ret_cls == CLS_W'(g)) && (cnt_q[g] != CNT_MAX))
        cnt_q[g] <= cnt_q[g] + CNT_W'(1);
    end
  end

  always_comb begin
    cls_cnt = '0;
    for (int i = 0; i < NUM_CLS; i++)
      if (cls_sel == CLS_W'(i)) cls_cnt = cnt_q[i];
  end

  assign rd_cycle = rd_valid ? cyc_mem[rd_ptr_q] : '0;
  assign rd_pc    = rd_valid ? pc_mem[rd_ptr_q]  : '0;
  assign rd_class = rd_valid ? cls_mem[rd_ptr_q] : '0;
  assign rd_wd    = rd_valid ? wd_mem[rd_ptr_q]  : '0;
  assign fill     = fill_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: class table, trigger, stop/wrap,
// full push+pop and mid-capture reset sequences.
module tb_mips_trace_buffer;

  localparam int DEPTH = 16;
  localparam int FW    = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        rst, retire_valid, cap_en, wrap_mode, trig_en, rd_ready, rd_valid, overflow;
  logic [31:0] retire_pc, retire_instr, retire_wd, trig_pc, rd_pc, rd_wd;
  logic [15:0] rd_cycle, drop_cnt, cls_cnt;
  logic [3:0]  rd_class, cls_sel;
  logic [FW-1:0] fill;

  int checks = 0;
  int errors = 0;

  mips_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .retire_wd(retire_wd), .cap_en(cap_en),
    .wrap_mode(wrap_mode), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_cycle(rd_cycle), .rd_pc(rd_pc),
    .rd_class(rd_class), .rd_wd(rd_wd), .fill(fill), .overflow(overflow),
    .drop_cnt(drop_cnt), .cls_sel(cls_sel), .cls_cnt(cls_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] I_ADD  = 32'h01095020;
  localparam logic [31:0] I_SUB  = 32'h01095022;
  localparam logic [31:0] I_AND  = 32'h01095024;
  localparam logic [31:0] I_OR   = 32'h01095025;
  localparam logic [31:0] I_SLT  = 32'h0109502A;
  localparam logic [31:0] I_ORI  = 32'h3508000F;
  localparam logic [31:0] I_LW   = 32'h8D090004;
  localparam logic [31:0] I_SW   = 32'hAD090004;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_ADDI = 32'h21080001;
  localparam logic [31:0] I_LUI  = 32'h3C081234;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  exp_cls;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] wd, input logic rdy);
    retire_valid = 1'b1;
    retire_pc    = pc;
    retire_instr = instr;
    retire_wd    = wd;
    rd_ready     = rdy;
    tick();
    retire_valid = 1'b0;
    rd_ready     = 1'b0;
  endtask

  task automatic pop();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{I_ADD,  4'd1};
    vecs[1]  = '{I_SUB,  4'd2};
    vecs[2]  = '{I_AND,  4'd3};
    vecs[3]  = '{I_OR,   4'd4};
    vecs[4]  = '{I_ORI,  4'd5};
    vecs[5]  = '{I_LW,   4'd6};
    vecs[6]  = '{I_SW,   4'd7};
    vecs[7]  = '{I_BEQ,  4'd8};
    vecs[8]  = '{I_J,    4'd9};
    vecs[9]  = '{I_SLT,  4'd0};
    vecs[10] = '{I_ADDI, 4'd0};
    vecs[11] = '{I_LUI,  4'd0};

    rst = 1'b1; retire_valid = 1'b0; retire_pc = '0; retire_instr = '0; retire_wd = '0;
    cap_en = 1'b0; wrap_mode = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
    cls_sel = 4'd0;

    // Reset state
    do_reset();
    chk("reset_fill", 64'(fill), 0);
    chk("reset_rd_valid", 64'(rd_valid), 0);
    chk("reset_overflow", 64'(overflow), 0);
    chk("reset_drop", 64'(drop_cnt), 0);
    chk("reset_rd_pc", 64'(rd_pc), 0);

    // Direct capture: enable edge -> CAPTURE (cycle 1), ADD at cycle 1, LW at cycle 2
    cap_en = 1'b1;
    tick();
    retire(32'h0, I_ADD, 32'd5, 1'b0);
    retire(32'h4, I_LW, 32'd9, 1'b0);
    chk("direct_fill", 64'(fill), 2);
    chk("direct_cls0", 64'(rd_class), 1);
    chk("direct_pc0", 64'(rd_pc), 0);
    chk("direct_wd0", 64'(rd_wd), 5);
    chk("direct_cyc0", 64'(rd_cycle), 1);
    pop();
    chk("direct_cls1", 64'(rd_class), 6);
    chk("direct_pc1", 64'(rd_pc), 4);
    chk("direct_cyc1", 64'(rd_cycle), 2);
    cls_sel = 4'd1;
    #1 chk("direct_cnt_add", 64'(cls_cnt), 1);
    pop();
    chk("direct_empty", 64'(rd_valid), 0);

    // Classification table
    do_reset();
    tick();
    for (int i = 0; i < 12; i++) retire(32'h200 + 32'(i * 4), vecs[i].instr, 32'(i), 1'b0);
    chk("table_fill", 64'(fill), 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("table_cls%0d", i), 64'(rd_class), 64'(vecs[i].exp_cls));
      chk($sformatf("table_pc%0d", i), 64'(rd_pc), 64'(32'h200 + 32'(i * 4)));
      pop();
    end

    // Trigger at 0x10 with ORI stream
    do_reset();
    trig_en = 1'b1; trig_pc = 32'h10;
    tick();
    trig_en = 1'b0;
    for (int i = 0; i < 8; i++) retire(32'(i * 4), I_ORI, 32'(i), 1'b0);
    chk("trig_fill", 64'(fill), 4);
    chk("trig_head_pc", 64'(rd_pc), 32'h10);
    cls_sel = 4'd5;
    #1 chk("trig_cnt_ori", 64'(cls_cnt), 4);
    cap_en = 1'b0;
    tick();
    retire(32'h40, I_ORI, 32'd0, 1'b0);
    chk("idle_fill_kept", 64'(fill), 4);
    chk("idle_head_kept", 64'(rd_pc), 32'h10);
    cap_en = 1'b1;

    // Stop mode: 20 retires into 16 entries
    do_reset();
    wrap_mode = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) retire(32'(i * 4), I_ADD, 32'(i), 1'b0);
    chk("stop_fill", 64'(fill), 16);
    chk("stop_head_pc", 64'(rd_pc), 0);
    chk("stop_drop", 64'(drop_cnt), 4);
    chk("stop_overflow", 64'(overflow), 1);
    cls_sel = 4'd1;
    #1 chk("stop_cnt_add", 64'(cls_cnt), 20);

    // Wrap mode: same stimulus
    do_reset();
    wrap_mode = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) retire(32'(i * 4), I_ADD, 32'(i), 1'b0);
    chk("wrap_fill", 64'(fill), 16);
    chk("wrap_head_pc", 64'(rd_pc), 32'h10);
    chk("wrap_drop", 64'(drop_cnt), 4);
    chk("wrap_overflow", 64'(overflow), 1);

    // Full with simultaneous push and pop
    chk("pp_popped_pc", 64'(rd_pc), 32'h10);
    retire(32'h100, I_SUB, 32'd7, 1'b1);
    chk("pp_fill", 64'(fill), 16);
    chk("pp_drop", 64'(drop_cnt), 4);
    chk("pp_head_pc", 64'(rd_pc), 32'h14);
    for (int i = 0; i < 15; i++) pop();
    chk("pp_last_pc", 64'(rd_pc), 32'h100);
    chk("pp_last_cls", 64'(rd_class), 2);
    chk("pp_last_fill", 64'(fill), 1);
    wrap_mode = 1'b0;

    // Reset mid-capture with fill=7
    do_reset();
    tick();
    for (int i = 0; i < 7; i++) retire(32'(i * 4), I_ADD, 32'(i), 1'b0);
    chk("mid_fill_pre", 64'(fill), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cls_sel = 4'd1;
    #1;
    chk("mid_fill", 64'(fill), 0);
    chk("mid_rd_valid", 64'(rd_valid), 0);
    chk("mid_cnt_add", 64'(cls_cnt), 0);
    chk("mid_drop", 64'(drop_cnt), 0);
    // First cycle after reset is IDLE, so this retire is not captured
    retire(32'h80, I_ADD, 32'd1, 1'b0);
    chk("mid_idle_nocap", 64'(fill), 0);
    retire(32'h84, I_ADD, 32'd2, 1'b0);
    chk("mid_fill_post", 64'(fill), 1);
    chk("mid_pc_post", 64'(rd_pc), 32'h84);
    chk("mid_cyc_post", 64'(rd_cycle), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_trace_buffer.md
Name: mips_trace_buffer

Overview:
- Synthesizable retire-trace capture block for the MIPS cores; the hardware successor to simulation-only $display PC/opcode tracing.
- Sits beside the CPU and observes one retire port per cycle.
- Classifies each retired instruction and stores {cycle, pc, class, wd} records in a parametrised circular buffer, read out over a valid/ready handshake.
- Adds PC trigger arming, stop/overwrite modes and saturating per-class counters.

Parameters:
- DEPTH, 16: buffer entries; power of two, >=2.
- PC_W, 32: PC width.
- DATA_W, 32: writeback data width.
- CYC_W, 16: cycle-stamp width.
- CNT_W, 16: class and drop counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-high.
- retire_valid  in  1  an instruction retires this cycle.
- retire_pc  in  PC_W  PC of the retiring instruction.
- retire_instr  in  32  instruction word.
- retire_wd  in  DATA_W  register-file write data.
- cap_en  in  1  capture enable.
- wrap_mode  in  1  1 = overwrite oldest when full; 0 = drop newest when full.
- trig_en  in  1  wait for trig_pc before capturing.
- trig_pc  in  PC_W  trigger PC.
- rd_valid  out  1  head record available.
- rd_ready  in  1  consumer accepts the head record.
- rd_cycle  out  CYC_W  head cycle stamp.
- rd_pc  out  PC_W  head PC.
- rd_class  out  4  head instruction class.
- rd_wd  out  DATA_W  head write data.
- fill  out  $clog2(DEPTH+1)  occupancy.
- overflow  out  1  sticky flag: a record was lost.
- drop_cnt  out  CNT_W  lost records, saturating.
- cls_sel  in  4  counter select.
- cls_cnt  out  CNT_W  count for the class selected by cls_sel, combinational mux.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, buffer pointers 0, fill=0, rd_valid=0, overflow=0, drop_cnt=0, all class counters 0, cycle counter 0. Output rd_* buses read 0 while fill=0.
- Cycle counter: free-running, increments every non-reset cycle, wraps modulo 2^CYC_W. The stamp records the counter value in the retire cycle.
- Classes: OTHER=0, ADD=1, SUB=2, AND=3, OR=4, ORI=5, LW=6, SW=7, BEQ=8, J=9. R-type (opcode 0) is decoded by funct 32/34/36/37. ORI=op13, LW=op35, SW=op43, BEQ=op4, J=op2. Anything else is OTHER.
- FSM states: IDLE, ARMED, CAPTURE.
  - IDLE -> CAPTURE if cap_en && !trig_en.
  - IDLE -> ARMED if cap_en && trig_en.
  - ARMED -> CAPTURE on retire_valid && retire_pc==trig_pc. The triggering instruction itself is captured in that same cycle.
  - Any state -> IDLE when cap_en=0. Buffer contents are retained and remain readable.
  - trig_en is sampled only in IDLE.
- Eligible retire: retire_valid && (state==CAPTURE || trigger hit in ARMED).
- On an eligible retire, class counter[class] increments, saturating at 2^CNT_W-1, whether or not the record is stored.
- Pop: rd_valid && rd_ready. Read is show-ahead: rd_* reflect the head combinationally from registered storage. A pushed record is visible on rd_* the cycle after the push.
- Push rules for an eligible retire:
  - fill<DEPTH: write the record; fill+1, or unchanged if a pop occurs in the same cycle.
  - fill==DEPTH with a pop in the same cycle: write; fill unchanged. No loss.
  - fill==DEPTH, no pop, wrap_mode=1: overwrite the oldest record and advance the read pointer; fill stays DEPTH; drop_cnt+1; overflow=1.
  - fill==DEPTH, no pop, wrap_mode=0: discard the new record; drop_cnt+1; overflow=1.
- Pointers wrap modulo DEPTH.
- overflow and drop_cnt are cleared only by rst.
- Reset mid-operation: all state returns to reset values in the next cycle. Any in-flight pop or push is lost.

Decomposition:
- Shared package mips_trace_pkg holds:
  - the class code localparams;
  - opcode and funct constants (shared with the CPU decoder);
  - a trace record struct/width constant.
- One combinational sub-module, mips_instr_classify: input instr[31:0], output class[3:0].
- The FIFO, FSM and counters stay in the top module.

Test Plan:
- Direct capture: rst, cap_en=1, trig_en=0; retire ADD (op0 fn32, pc 0x0, wd 5) then LW (op35, pc 0x4). Required: fill=2; first pop gives class 1, pc 0, wd 5; second pop gives class 6, pc 4; cls_sel=1 gives cls_cnt=1.
- Trigger: trig_en=1, trig_pc=0x10; retire pcs 0x0, 0x4, ..., 0x1C. Required: first record pc=0x10, fill=4, and the ORI class count covers only instructions from 0x10 onward.
- Stop mode, DEPTH=16, no reads: retire 20 instructions. Required: fill=16, the oldest pc is the first one, drop_cnt=4, overflow=1.
- Wrap mode with the same stimulus: fill=16, head pc is the 5th instruction, drop_cnt=4.
- Full with a simultaneous pop and push: no drop, fill stays 16, and the popped record equals the old head.
- rst asserted mid-capture with fill=7: the next cycle shows fill=0, rd_valid=0, all counters 0 and state IDLE. Cycle stamps restart at 0.
